imem_loader: RTL and testbench

Boot-time writer for the 256×32 instruction memory. Receives a framed byte stream (e.g. from a UART receiver), packs bytes little-endian into 32-bit words and issues single-cycle writes to the instruction RAM write port. It holds the CPU in reset while a load is in progress and reports completion or error. The CPU side keeps its combinational read port, indexed by `addr[7:0]`.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_byte_packer.sv | 47 ++++
 rtl/imem_loader.sv | 209 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the boot-time instruction memory loader.
//   - state_t      : loader FSM states
//   - DEFAULT_SYNC : default frame start byte
//   - IMEM_WORDS   : instruction RAM depth in words (shared with the RAM)
//   - IMEM_AW      : instruction RAM word-address width
//   - frame_len()  : assembles the 16-bit little-endian word count
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;
    localparam int         IMEM_WORDS   = 256;
    localparam int         IMEM_AW      = 8;

    // The length field arrives low byte first.
    function automatic logic [15:0] frame_len(input logic [7:0] lo,
                                              input logic [7:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Packs four consecutive bytes little-endian into a 32-bit word. Byte 0 is
// the first one received and lands in word[7:0].
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   byte_data [7:0]: incoming byte
//   byte_valid     : byte_data is consumed this cycle
//   word_data [31] : assembled word, valid while word_valid is high
//   word_valid     : high for the single cycle the 4th byte is consumed
//   byte_idx  [1:0]: position the next byte will occupy in the word
// ---------------------------------------------------------------------------
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic [31:0] word_data,
    output logic        word_valid,
    output logic [1:0]  byte_idx
);

    logic [1:0]  byte_cnt;
    logic [23:0] low_bytes;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    low_bytes[7:0]   <= byte_data;
                2'd1:    low_bytes[15:8]  <= byte_data;
                2'd2:    low_bytes[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

    // The 4th byte is combined directly so the top can register the write
    // in the same edge that accepts it, giving a one-cycle write latency.
    assign word_valid = byte_valid && (byte_cnt == 2'd3);
    assign word_data  = {byte_data, low_bytes};
    assign byte_idx   = byte_cnt;

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the 256x32 instruction memory. Parses a framed byte
// stream  SYNC, LEN_LO, LEN_HI, 4*N data bytes [, CSUM]  and issues one
// registered write per assembled word while holding the CPU in reset.
//
// Configuration macro: IMEM_LOADER_CHECKSUM_EN
//   defined   : a trailing checksum byte (8-bit sum of data bytes) is
//               expected; mismatch raises error.
//   undefined : the frame ends after the last data byte.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_data  [7:0]  : received byte
//   in_valid        : in_data valid this cycle
//   in_ready        : byte accepted when in_valid && in_ready (no
//                     backpressure; low only while in reset)
//   mem_we          : one-cycle RAM write strobe
//   mem_waddr[7:0]  : word address (word index within the frame)
//   mem_wdata[31:0] : packed word
//   cpu_hold        : keeps the CPU in reset while a load is in progress
//   done            : sticky, last load succeeded
//   error           : sticky, last load failed
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [7:0] BYTE_SYNC = DEFAULT_SYNC,
    parameter int         MAX_WORDS = IMEM_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [IMEM_AW-1:0] mem_waddr,
    output logic [31:0]        mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               error
);

    state_t      state;
    logic [7:0]  len_lo;
    logic [8:0]  n_words;
    logic [8:0]  word_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    logic        accept;
    logic        sync_seen;
    logic        data_accept;
    logic        last_word;
    logic [15:0] len_full;
    logic [31:0] word_data;
    logic        word_valid;
    logic [1:0]  byte_idx;

    assign accept      = in_valid && in_ready;
    assign sync_seen   = accept && (in_data == BYTE_SYNC);
    assign data_accept = accept && (state == DATA);
    assign len_full    = frame_len(len_lo, in_data);
    // n_words is at least 1 and at most 256 whenever DATA is active.
    assign last_word   = (word_cnt == (n_words - 9'd1));

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_data  (in_data),
        .byte_valid (data_accept),
        .word_data  (word_data),
        .word_valid (word_valid),
        .byte_idx   (byte_idx)
    );

    // Write port registers: valid exactly one cycle after the 4th byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= 32'd0;
        end else begin
            mem_we <= word_valid;
            if (word_valid) begin
                mem_waddr <= word_cnt[IMEM_AW-1:0];
                mem_wdata <= word_data;
            end
        end
    end

    // No backpressure: ready is simply "out of reset".
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= 1'b1;
        end
    end

    // Frame FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len_lo   <= 8'd0;
            n_words  <= 9'd0;
            word_cnt <= 9'd0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= 8'd0;
`endif
        end else begin
            case (state)
                // DONE and ERR only differ from IDLE in the sticky flags.
                IDLE, DONE, ERR: begin
                    if (sync_seen) begin
                        state    <= LEN_LO;
                        word_cnt <= 9'd0;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum      <= 8'd0;
`endif
                    end
                end

                LEN_LO: begin
                    if (accept) begin
                        len_lo <= in_data;
                        state  <= LEN_HI;
                    end
                end

                LEN_HI: begin
                    if (accept) begin
                        // Rejecting oversize frames here guarantees the
                        // 8-bit write address never wraps.
                        if (len_full > 16'(MAX_WORDS)) begin
                            state    <= ERR;
                            error    <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state    <= CSUM;
`else
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            n_words <= len_full[8:0];
                            state   <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum <= sum + in_data;
`endif
                        if (word_valid) begin
                            word_cnt <= word_cnt + 9'd1;
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state    <= CSUM;
`else
                                state    <= DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
`endif
                            end
                        end
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        cpu_hold <= 1'b0;
                        if (in_data == sum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state    <= IDLE;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

    // The packer's byte position is not needed by the FSM: a frame can only
    // leave DATA on a word boundary, so the position is always 0 outside it.
    logic unused_ok;
    assign unused_ok = ^byte_idx;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader. Frames are built into frame_q, the
// expected RAM writes into exp_q; a negedge monitor matches every mem_we
// pulse against exp_q. Works with or without IMEM_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          prev_cyc = 0;
    bit          have_prev  = 1'b0;
    bit          spacing_en = 1'b0;
    logic        last_we    = 1'b0;
    logic [39:0] exp_w;
    logic [39:0] exp_q[$];
    logic [7:0]  frame_q[$];
    logic [7:0]  tb_sum;

    imem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            check("we_one_cycle", 40'(last_we), 40'd0);
            if (spacing_en && have_prev) check("we_spacing", 40'(cyc - prev_cyc), 40'd4);
            have_prev = 1'b1;
            prev_cyc  = cyc;
            check("write_expected", 40'(exp_q.size() > 0), 40'd1);
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                check("write_addr_data", {mem_waddr, mem_wdata}, exp_w);
            end
        end
        last_we = mem_we;
    end

    // ---------------- frame building ----------------
    task automatic push_header(input logic [15:0] n);
        frame_q.push_back(8'hA5);
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        tb_sum = 8'd0;
    endtask

    task automatic push_word(input logic [7:0] addr, input logic [31:0] w, input bit expect_write);
        for (int k = 0; k < 4; k++) begin
            frame_q.push_back(w[8*k +: 8]);
            tb_sum = tb_sum + w[8*k +: 8];
        end
        if (expect_write) exp_q.push_back({addr, w});
    endtask

    task automatic push_csum(input logic [7:0] c);
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(c);
`else
        c = c; // no checksum byte in this build
`endif
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends frame_q back to back. cpu_hold must be high after every byte
    // except the final one of a complete frame; flags clear after SYNC.
    task automatic send_frame(input bit ends_frame);
        int n;
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            send_byte(frame_q[i]);
            if (i == 0) begin
                check("done_clr_on_sync", 40'(done), 40'd0);
                check("error_clr_on_sync", 40'(error), 40'd0);
            end
            if (!ends_frame || i < n - 1) check("cpu_hold_busy", 40'(cpu_hold), 40'd1);
        end
        frame_q.delete();
    endtask

    task automatic expect_status(input string tag, input logic d, input logic e);
        check({tag, "_done"}, 40'(done), 40'(d));
        check({tag, "_error"}, 40'(error), 40'(e));
        check({tag, "_hold"}, 40'(cpu_hold), 40'd0);
    endtask

    task automatic drain(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check(tag, 40'(exp_q.size()), 40'd0);
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 40'(in_ready), 40'd0);
        check({tag, "_mem_we"}, 40'(mem_we), 40'd0);
        check({tag, "_waddr"}, 40'(mem_waddr), 40'd0);
        check({tag, "_wdata"}, 40'(mem_wdata), 40'd0);
        check({tag, "_hold"}, 40'(cpu_hold), 40'd0);
        check({tag, "_done"}, 40'(done), 40'd0);
        check({tag, "_error"}, 40'(error), 40'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        in_data  = 8'd0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 40'(in_ready), 40'd1);

        // Two-word load: data sum 13+93+10 = B6.
        push_header(16'd2);
        push_word(8'd0, 32'h0000_0013, 1'b1);
        push_word(8'd1, 32'h0010_0093, 1'b1);
        push_csum(8'hB6);
        send_frame(1'b1);
        expect_status("load", 1'b1, 1'b0);
        drain("load_writes");

        // Non-sync byte while idle is discarded.
        send_byte(8'h5A);
        expect_status("discard", 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: writes still land, error raised.
        push_header(16'd2);
        push_word(8'd0, 32'h0000_0013, 1'b1);
        push_word(8'd1, 32'h0010_0093, 1'b1);
        push_csum(8'hC8);
        send_frame(1'b1);
        expect_status("bad_csum", 1'b0, 1'b1);
        drain("bad_csum_writes");
`endif

        // Over-length (N = 257): error, no writes.
        push_header(16'h0101);
        send_frame(1'b1);
        expect_status("over_len", 1'b0, 1'b1);
        drain("over_len_writes");

        // Valid frame after an error.
        push_header(16'd1);
        push_word(8'd0, 32'hDEAD_BEEF, 1'b1);
        push_csum(8'hDE + 8'hAD + 8'hBE + 8'hEF);
        send_frame(1'b1);
        expect_status("recover", 1'b1, 1'b0);
        drain("recover_writes");

        // Zero length.
        push_header(16'd0);
        push_csum(8'h00);
        send_frame(1'b1);
        expect_status("zero_len", 1'b1, 1'b0);
        drain("zero_len_writes");

        // Full depth: word i = i, sum of 0..255 mod 256 = 0x80.
        push_header(16'd256);
        for (int i = 0; i < 256; i++) push_word(8'(i), 32'(i), 1'b1);
        push_csum(8'h80);
        have_prev  = 1'b0;
        spacing_en = 1'b1;
        send_frame(1'b1);
        expect_status("full", 1'b1, 1'b0);
        drain("full_writes");
        spacing_en = 1'b0;

        // Reset after byte 2 of word 5: words 0..4 land, word 5 never does.
        push_header(16'd8);
        for (int i = 0; i < 5; i++) push_word(8'(i), 32'hC0DE_0000 + 32'(i), 1'b1);
        frame_q.push_back(8'h11);
        frame_q.push_back(8'h22);
        send_frame(1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_reset_outputs("mid_reset");
        rst = 1'b0;
        drain("mid_reset_writes");

        // Subsequent frame loads correctly, including address 5.
        push_header(16'd6);
        for (int i = 0; i < 6; i++) push_word(8'(i), 32'h1234_5600 + 32'(i), 1'b1);
        push_csum(tb_sum);
        send_frame(1'b1);
        expect_status("after_reset", 1'b1, 1'b0);
        drain("after_reset_writes");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
